serial_magnitude_comparator: RTL and testbench
==============================================

Name: serial_magnitude_comparator

Overview:
- Multi-cycle magnitude comparator for two WIDTH-bit operands, with both width and signedness selectable.
- Operands are captured on a start strobe and compared MSB-first, DIGIT bits per clock.
- The comparison terminates early on the first differing digit.
- Registered one-hot less/equal/greater flags are produced with a done pulse.
- Used where wide compares must not sit on the critical path, e.g. threshold checks in datapath control.

Parameters:
WIDTH, 16, operand width in bits; must be an integer multiple of DIGIT, WIDTH >= 2
DIGIT, 2, bits compared per clock cycle; 1 <= DIGIT <= WIDTH
NUM_DIGITS (localparam), WIDTH/DIGIT, maximum compare cycles

Ports:
clock  input  1  system clock, all state updates on rising edge
reset  input  1  synchronous, active-high reset
start  input  1  request; sampled only in IDLE
signed_mode  input  1  1 = two's-complement compare, 0 = unsigned; sampled with start
a  input  WIDTH  operand A; sampled with start
b  input  WIDTH  operand B; sampled with start
busy  output  1  high while a compare is in progress
done  output  1  one-cycle pulse when result flags update
a_less_b  output  1  registered result, A < B
a_equal_b  output  1  registered result, A == B
a_greater_b  output  1  registered result, A > B

Behaviour:
- One clock domain; reset is synchronous and active-high.
- Reset values: state=IDLE, busy=0, done=0, a_less_b=0, a_equal_b=0, a_greater_b=0, and the operand and digit-index registers are cleared.
- Result flags are all-zero until the first completed compare. After that they are exactly one-hot.
- FSM states: IDLE and COMPARE.
- IDLE:
  - If start=1 at an edge, capture a, b and signed_mode into internal registers.
  - If signed_mode=1, invert the MSB of both captured operands. This is an offset-binary transform, so the unsigned compare then yields the signed order.
  - Set digit index to 0 (MSB digit), go to COMPARE, busy=1 from the next cycle.
- COMPARE:
  - Each edge compares digit j = bits [WIDTH-1-j*DIGIT -: DIGIT] of both captured operands.
  - If digits differ: update the flags (less or greater per the digit compare), pulse done=1, busy=0, return to IDLE.
  - If digits are equal and j = NUM_DIGITS-1: set a_equal_b=1 with the others 0, pulse done, return to IDLE.
  - Otherwise j increments and the FSM stays in COMPARE.
- Latency: with start sampled at edge k, done is high during the cycle following edge k+1+j, where j is the index of the first differing digit (j = NUM_DIGITS-1 for equal operands). The minimum latency is 1 compare cycle; the maximum is NUM_DIGITS.
- Result flags change only on the edge that raises done. They hold their value until the next done.
- done is never high for two consecutive cycles from a single compare.
- start while busy=1 is ignored. It is not queued and the captured operands are unaffected.
- start may be asserted in the same cycle done is high. The FSM is in IDLE then, so it is accepted and back-to-back compares have no bubble.
- Inputs a, b and signed_mode may change freely after the capture edge without affecting the result.
- Reset mid-compare: on the next edge all state returns to reset values. The flags clear to all-zero and no done is issued for the aborted compare.
- Reset has priority over start in the same cycle.
- DIGIT = WIDTH degenerates to a registered single-cycle compare (latency 1).

Test Plan:
- All cases use WIDTH=8, DIGIT=2.
- Unsigned early exit: a=0xC3, b=0x43, signed_mode=0, start for 1 cycle -> busy for 1 cycle, done on first compare cycle, a_greater_b=1, other flags 0.
- Signed order: a=0xC3 (-61), b=0x43 (+67), signed_mode=1 -> done after 1 compare cycle, a_less_b=1. Also a=0x80, b=0x7F signed -> a_less_b=1; unsigned -> a_greater_b=1.
- Full-length compares:
  - a=0x5A, b=0x5A -> done exactly 4 compare cycles after capture, a_equal_b=1.
  - a=0x10, b=0x11 -> done after 4 cycles, a_less_b=1.
- Handshake:
  - Start re-asserted with a=0x00, b=0xFF while busy -> ignored, and the first result is unchanged.
  - Start asserted in the done cycle with a=0xFF, b=0x00 -> accepted, and next done gives a_greater_b=1 with no idle gap.
  - Operands changed after the capture edge -> result reflects the captured values.
- Reset: reset asserted during cycle 2 of a compare of a=0x10, b=0x11 -> next edge busy=0, done=0, all flags 0, no later done. Reset and start together -> remains IDLE.
- Reset values and hold: after reset deassertion, all outputs are 0. Flags hold their last result across 10 idle cycles with start=0.

Source files
------------

// File: rtl/serial_magnitude_comparator.sv
// Multi-cycle magnitude comparator: operands are captured on start and
// compared MSB-first, DIGIT bits per clock, stopping at the first differing
// digit. Signed compares are handled by flipping both MSBs at capture
// (offset binary), so the digit datapath is always an unsigned compare.
module serial_magnitude_comparator #(
    parameter int WIDTH = 16,
    parameter int DIGIT = 2
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic             signed_mode,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic             a_less_b,
    output logic             a_equal_b,
    output logic             a_greater_b
);

    localparam int NUM_DIGITS = WIDTH / DIGIT;
    localparam int IDX_W      = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

    typedef enum logic {
        IDLE    = 1'b0,
        COMPARE = 1'b1
    } state_t;

    state_t             state;
    state_t             next_state;
    logic [WIDTH-1:0]   op_a;
    logic [WIDTH-1:0]   op_b;
    logic [IDX_W-1:0]   digit_idx;
    logic [IDX_W-1:0]   next_idx;
    logic [DIGIT-1:0]   a_digit;
    logic [DIGIT-1:0]   b_digit;
    logic               next_done;
    logic               next_less;
    logic               next_equal;
    logic               next_greater;
    logic               capture;
    logic [WIDTH-1:0]   msb_flip;

    // Signed mode is folded into the captured operands, so it needs no register.
    assign msb_flip = signed_mode ? {1'b1, {(WIDTH-1){1'b0}}} : '0;
    assign capture  = (state == IDLE) && start;
    assign busy     = (state == COMPARE);

    // Select the current digit of each operand, MSB digit at index 0.
    always_comb begin
        a_digit = '0;
        b_digit = '0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (digit_idx == IDX_W'(i)) begin
                a_digit = op_a[WIDTH-1-i*DIGIT -: DIGIT];
                b_digit = op_b[WIDTH-1-i*DIGIT -: DIGIT];
            end
        end
    end

    // Next-state, digit index and result decisions; flags hold unless done rises.
    always_comb begin
        next_state   = state;
        next_idx     = digit_idx;
        next_done    = 1'b0;
        next_less    = a_less_b;
        next_equal   = a_equal_b;
        next_greater = a_greater_b;
        case (state)
            IDLE: begin
                if (start) begin
                    next_state = COMPARE;
                    next_idx   = '0;
                end
            end
            COMPARE: begin
                if (a_digit != b_digit) begin
                    next_less    = (a_digit < b_digit);
                    next_equal   = 1'b0;
                    next_greater = (a_digit > b_digit);
                    next_done    = 1'b1;
                    next_state   = IDLE;
                end else if (digit_idx == IDX_W'(NUM_DIGITS - 1)) begin
                    next_less    = 1'b0;
                    next_equal   = 1'b1;
                    next_greater = 1'b0;
                    next_done    = 1'b1;
                    next_state   = IDLE;
                end else begin
                    next_idx = digit_idx + IDX_W'(1);
                end
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    // State, operand capture and registered result flags with synchronous reset.
    always_ff @(posedge clock) begin
        if (reset) begin
            state       <= IDLE;
            op_a        <= '0;
            op_b        <= '0;
            digit_idx   <= '0;
            done        <= 1'b0;
            a_less_b    <= 1'b0;
            a_equal_b   <= 1'b0;
            a_greater_b <= 1'b0;
        end else begin
            state       <= next_state;
            digit_idx   <= next_idx;
            done        <= next_done;
            a_less_b    <= next_less;
            a_equal_b   <= next_equal;
            a_greater_b <= next_greater;
            if (capture) begin
                op_a <= a ^ msb_flip;
                op_b <= b ^ msb_flip;
            end
        end
    end

endmodule

// File: tb/tb_serial_magnitude_comparator.sv
// Self-checking bench for serial_magnitude_comparator (WIDTH=8, DIGIT=2),
// using a behavioural model built on plain signed/unsigned arithmetic.
module tb_serial_magnitude_comparator;

    localparam int WIDTH      = 8;
    localparam int DIGIT      = 2;
    localparam int NUM_DIGITS = WIDTH / DIGIT;
    localparam int MAX_WAIT   = 20;

    logic             clock = 1'b0;
    logic             reset = 1'b1;
    logic             start = 1'b0;
    logic             signed_mode = 1'b0;
    logic [WIDTH-1:0] a = '0;
    logic [WIDTH-1:0] b = '0;
    logic             busy;
    logic             done;
    logic             a_less_b;
    logic             a_equal_b;
    logic             a_greater_b;

    int checks = 0;
    int errors = 0;

    serial_magnitude_comparator #(.WIDTH(WIDTH), .DIGIT(DIGIT)) dut (
        .clock       (clock),
        .reset       (reset),
        .start       (start),
        .signed_mode (signed_mode),
        .a           (a),
        .b           (b),
        .busy        (busy),
        .done        (done),
        .a_less_b    (a_less_b),
        .a_equal_b   (a_equal_b),
        .a_greater_b (a_greater_b)
    );

    // Free-running clock.
    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Expected flags {less, equal, greater} from ordinary integer comparison.
    function automatic logic [2:0] exp_flags(logic [WIDTH-1:0] x, logic [WIDTH-1:0] y, logic sm);
        int xv;
        int yv;
        if (sm) begin
            xv = int'($signed(x));
            yv = int'($signed(y));
        end else begin
            xv = int'(x);
            yv = int'(y);
        end
        return {xv < yv, xv == yv, xv > yv};
    endfunction

    // Expected compare cycles: 1 + index of the first differing MSB-first digit.
    function automatic int exp_latency(logic [WIDTH-1:0] x, logic [WIDTH-1:0] y);
        logic [WIDTH-1:0] d;
        d = x ^ y;
        for (int p = WIDTH - 1; p >= 0; p--) begin
            if (d[p]) return (WIDTH - 1 - p) / DIGIT + 1;
        end
        return NUM_DIGITS;
    endfunction

    // Issue one compare, scramble inputs after capture, wait (bounded) for done.
    task automatic run_compare(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y,
                               input logic sm, output int cycles,
                               output logic [2:0] flags, output logic busy_first);
        start       = 1'b1;
        a           = x;
        b           = y;
        signed_mode = sm;
        tick();
        start       = 1'b0;
        a           = WIDTH'($urandom);
        b           = WIDTH'($urandom);
        signed_mode = 1'($urandom);
        busy_first  = busy;
        cycles      = 0;
        while (done !== 1'b1 && cycles < MAX_WAIT) begin
            tick();
            cycles++;
        end
        flags = {a_less_b, a_equal_b, a_greater_b};
    endtask

    task automatic test_reset();
        reset = 1'b1;
        tick();
        tick();
        checks++;
        if ({busy, done, a_less_b, a_equal_b, a_greater_b} !== 5'b0) begin
            errors++;
            $display("[TB] FAIL reset_held: got %b expected 00000",
                     {busy, done, a_less_b, a_equal_b, a_greater_b});
        end
        reset = 1'b0;
        tick();
        checks++;
        if ({busy, done, a_less_b, a_equal_b, a_greater_b} !== 5'b0) begin
            errors++;
            $display("[TB] FAIL reset_release: got %b expected 00000",
                     {busy, done, a_less_b, a_equal_b, a_greater_b});
        end
    endtask

    task automatic test_directed();
        logic [WIDTH-1:0] va [6] = '{8'hC3, 8'hC3, 8'h80, 8'h80, 8'h5A, 8'h10};
        logic [WIDTH-1:0] vb [6] = '{8'h43, 8'h43, 8'h7F, 8'h7F, 8'h5A, 8'h11};
        logic             vs [6] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
        int cycles;
        logic [2:0] flags;
        logic bf;
        for (int i = 0; i < 6; i++) begin
            run_compare(va[i], vb[i], vs[i], cycles, flags, bf);
            checks++;
            if (cycles != exp_latency(va[i], vb[i])) begin
                errors++;
                $display("[TB] FAIL directed_latency[%0d]: got %0d expected %0d",
                         i, cycles, exp_latency(va[i], vb[i]));
            end
            checks++;
            if (flags !== exp_flags(va[i], vb[i], vs[i])) begin
                errors++;
                $display("[TB] FAIL directed_flags[%0d]: got %b expected %b",
                         i, flags, exp_flags(va[i], vb[i], vs[i]));
            end
            checks++;
            if (bf !== 1'b1 || busy !== 1'b0) begin
                errors++;
                $display("[TB] FAIL directed_busy[%0d]: got first=%b done_cycle=%b expected 1 0",
                         i, bf, busy);
            end
            tick();
            checks++;
            if (done !== 1'b0) begin
                errors++;
                $display("[TB] FAIL directed_done_pulse[%0d]: got %b expected 0", i, done);
            end
        end
    endtask

    task automatic test_random();
        logic [WIDTH-1:0] x;
        logic [WIDTH-1:0] y;
        logic sm;
        int cycles;
        logic [2:0] flags;
        logic bf;
        for (int i = 0; i < 40; i++) begin
            x  = WIDTH'($urandom);
            sm = 1'($urandom);
            case ($urandom_range(0, 3))
                0:       y = WIDTH'($urandom);
                1:       y = x;
                2:       y = x ^ (WIDTH'(1) << $urandom_range(0, WIDTH - 1));
                default: y = x + WIDTH'(1);
            endcase
            run_compare(x, y, sm, cycles, flags, bf);
            checks++;
            if (cycles != exp_latency(x, y) || flags !== exp_flags(x, y, sm) || bf !== 1'b1) begin
                errors++;
                $display("[TB] FAIL random[%0d] a=%h b=%h s=%b: got lat=%0d flags=%b busy=%b expected lat=%0d flags=%b busy=1",
                         i, x, y, sm, cycles, flags, bf, exp_latency(x, y), exp_flags(x, y, sm));
            end
        end
    endtask

    task automatic test_busy_ignore();
        int cycles;
        start       = 1'b1;
        a           = 8'h10;
        b           = 8'h11;
        signed_mode = 1'b0;
        tick();
        a = 8'h00;
        b = 8'hFF;
        tick();
        tick();
        start  = 1'b0;
        cycles = 2;
        while (done !== 1'b1 && cycles < MAX_WAIT) begin
            tick();
            cycles++;
        end
        checks++;
        if (cycles != 4 || {a_less_b, a_equal_b, a_greater_b} !== 3'b100) begin
            errors++;
            $display("[TB] FAIL busy_ignore: got lat=%0d flags=%b expected lat=4 flags=100",
                     cycles, {a_less_b, a_equal_b, a_greater_b});
        end
        for (int i = 0; i < 6; i++) begin
            tick();
            checks++;
            if (done !== 1'b0 || busy !== 1'b0) begin
                errors++;
                $display("[TB] FAIL busy_ignore_queued[%0d]: got done=%b busy=%b expected 0 0",
                         i, done, busy);
            end
        end
    endtask

    task automatic test_back_to_back();
        int cycles;
        logic [2:0] flags;
        logic bf;
        logic [WIDTH-1:0] x;
        logic [WIDTH-1:0] y;
        logic sm;
        run_compare(8'hC3, 8'h43, 1'b0, cycles, flags, bf);
        checks++;
        if (cycles != 1 || flags !== 3'b001) begin
            errors++;
            $display("[TB] FAIL b2b_first: got lat=%0d flags=%b expected lat=1 flags=001", cycles, flags);
        end
        for (int i = 0; i < 6; i++) begin
            if (i == 0) begin
                x  = 8'hFF;
                y  = 8'h00;
                sm = 1'b0;
            end else begin
                x  = WIDTH'($urandom);
                y  = WIDTH'($urandom);
                sm = 1'($urandom);
            end
            run_compare(x, y, sm, cycles, flags, bf);
            checks++;
            if (bf !== 1'b1 || cycles != exp_latency(x, y) || flags !== exp_flags(x, y, sm)) begin
                errors++;
                $display("[TB] FAIL b2b[%0d] a=%h b=%h s=%b: got busy=%b lat=%0d flags=%b expected busy=1 lat=%0d flags=%b",
                         i, x, y, sm, bf, cycles, flags, exp_latency(x, y), exp_flags(x, y, sm));
            end
        end
        tick();
    endtask

    task automatic test_hold();
        logic [2:0] held;
        held = {a_less_b, a_equal_b, a_greater_b};
        for (int i = 0; i < 10; i++) begin
            a = WIDTH'($urandom);
            b = WIDTH'($urandom);
            tick();
            checks++;
            if ({a_less_b, a_equal_b, a_greater_b} !== held || done !== 1'b0) begin
                errors++;
                $display("[TB] FAIL hold[%0d]: got flags=%b done=%b expected flags=%b done=0",
                         i, {a_less_b, a_equal_b, a_greater_b}, done, held);
            end
        end
    endtask

    task automatic test_reset_mid();
        start       = 1'b1;
        a           = 8'h10;
        b           = 8'h11;
        signed_mode = 1'b0;
        tick();
        start = 1'b0;
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        checks++;
        if ({busy, done, a_less_b, a_equal_b, a_greater_b} !== 5'b0) begin
            errors++;
            $display("[TB] FAIL reset_mid: got %b expected 00000",
                     {busy, done, a_less_b, a_equal_b, a_greater_b});
        end
        for (int i = 0; i < 6; i++) begin
            tick();
            checks++;
            if (done !== 1'b0 || busy !== 1'b0) begin
                errors++;
                $display("[TB] FAIL reset_mid_late_done[%0d]: got done=%b busy=%b expected 0 0",
                         i, done, busy);
            end
        end
        reset = 1'b1;
        start = 1'b1;
        tick();
        reset = 1'b0;
        start = 1'b0;
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("[TB] FAIL reset_start_priority: got busy=%b expected 0", busy);
        end
        tick();
        checks++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            errors++;
            $display("[TB] FAIL reset_start_idle: got busy=%b done=%b expected 0 0", busy, done);
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_hold();
        test_random();
        test_busy_ignore();
        test_back_to_back();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
